// File: rtl/dmem_responder_if.sv
// Load/store bus between the core's memory wrapper (master) and the
// data-memory responder (slave). The err signal only exists when the
// DMEM_RANGE_CHECK_EN macro is defined.
interface dmem_responder_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32
);
  logic                   mem_en;
  logic                   Load;
  logic [DataWidth/8-1:0] masking;
  logic [AddrWidth-1:0]   addr;
  logic [DataWidth-1:0]   data_i;
  logic                   ready;
  logic                   data_valid;
  logic [DataWidth-1:0]   data_o;
`ifdef DMEM_RANGE_CHECK_EN
  logic                   err;
`endif

  modport master (
    output mem_en, Load, masking, addr, data_i,
    input  ready, data_valid, data_o
`ifdef DMEM_RANGE_CHECK_EN
    , input err
`endif
  );

  modport slave (
    input  mem_en, Load, masking, addr, data_i,
    output ready, data_valid, data_o
`ifdef DMEM_RANGE_CHECK_EN
    , output err
`endif
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one store or load at a time, performs the
// RAM access after a programmable latency and answers with a one-cycle
// data_valid pulse. Define DMEM_RANGE_CHECK_EN to flag addresses beyond the
// RAM (err output, no write, zero read data) instead of wrapping them.
module dmem_responder #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned Depth     = 1024,
  parameter int unsigned Latency   = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int unsigned IdxW  = $clog2(Depth);
  localparam int unsigned Lanes = DataWidth / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q;
  logic [IdxW-1:0]        idx_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [Lanes-1:0]       mask_q;
  logic                   store_q;
  logic [DataWidth-1:0]   data_q;
  logic                   in_range;
  logic                   req;
  logic                   access;
  logic                   ready_c;
  logic                   valid_c;
  logic [DataWidth-1:0]   ram [Depth];

  assign req    = bus.mem_en | bus.Load;
  assign access = (state_q == WAIT) && (cnt_q == '0);

`ifdef DMEM_RANGE_CHECK_EN
  logic oob_q;
  logic unused_addr;
  assign unused_addr = ^bus.addr[1:0];
  assign in_range    = ~oob_q;
  assign bus.err     = (state_q == RESP) && oob_q;

  // Out-of-range flag captured with the request, held until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oob_q <= 1'b0;
    end else if (state_q == IDLE && req) begin
      oob_q <= |bus.addr[AddrWidth-1:IdxW+2];
    end
  end
`else
  // Upper address bits are dropped: accesses wrap modulo the RAM size
  logic unused_addr;
  assign unused_addr = ^{bus.addr[AddrWidth-1:IdxW+2], bus.addr[1:0]};
  assign in_range    = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    valid_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (req) state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
      end
      RESP: begin
        valid_c = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready      = ready_c;
  assign bus.data_valid = valid_c;
  assign bus.data_o     = data_q;

  // Request capture, latency counter and registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      store_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        idx_q   <= bus.addr[IdxW+1:2];
        wdata_q <= bus.data_i;
        mask_q  <= bus.masking;
        store_q <= bus.mem_en;
        cnt_q   <= 4'(Latency - 1);
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (access && !in_range) begin
        data_q <= '0;
      end else if (access && !store_q) begin
        data_q <= ram[idx_q];
      end
    end
  end

  // Byte-masked RAM write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (access && store_q && in_range) begin
      for (int unsigned i = 0; i < Lanes; i++) begin
        if (mask_q[i]) ram[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (Latency 2, Depth 1024). Expected
// responses are queued when a request is driven and popped by a monitor on
// data_valid. Build with DMEM_RANGE_CHECK_EN defined to cover the err path.
module tb_dmem_responder;
  localparam int unsigned Latency = 2;
  localparam int unsigned Depth   = 1024;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dmem_responder_if #(.DataWidth(32), .AddrWidth(32)) bus ();

  dmem_responder #(
    .DataWidth(32),
    .AddrWidth(32),
    .Depth    (Depth),
    .Latency  (Latency)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          dv_count = 0;
  resp_t       sb_q[$];
  logic [31:0] mem_model [Depth];
  logic [31:0] model_dout = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Response monitor: every data_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.data_valid === 1'b1) begin
      resp_t e;
      dv_count++;
      if (sb_q.size() == 0) begin
        check("unexpected_dv", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("data_o", bus.data_o, e.data);
`ifdef DMEM_RANGE_CHECK_EN
        check("err", {31'd0, bus.err}, {31'd0, e.err});
`endif
      end
    end
  end

  function automatic logic is_oob(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return a >= 32'(Depth * 4);
`else
    return 1'b0;
`endif
  endfunction

  // Issue one request, update the model, and check handshake timing.
  // busy_ld keeps a load to 0x10 asserted while the responder is busy.
  task automatic txn(input logic st, input logic ld, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m, input logic busy_ld);
    resp_t e;
    int    n;
    logic [9:0] idx;
    n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
    idx   = a[11:2];
    e.err = is_oob(a);
    if (st) begin
      if (!e.err) begin
        for (int i = 0; i < 4; i++) if (m[i]) mem_model[idx][8*i +: 8] = d[8*i +: 8];
      end
      e.data = e.err ? 32'd0 : model_dout;
    end else begin
      e.data = e.err ? 32'd0 : mem_model[idx];
    end
    model_dout = e.data;
    sb_q.push_back(e);
    bus.mem_en  = st;
    bus.Load    = ld;
    bus.addr    = a;
    bus.data_i  = d;
    bus.masking = m;
    @(posedge clk);
    @(negedge clk);
    bus.mem_en = 1'b0;
    bus.Load   = busy_ld;
    if (busy_ld) bus.addr = 32'h10;
    check("ready_busy", {31'd0, bus.ready}, 32'd0);
    n = 1;
    while (bus.data_valid !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
      if (bus.data_valid !== 1'b1) check("ready_wait", {31'd0, bus.ready}, 32'd0);
    end
    check("dv_latency", 32'(n), 32'(Latency + 1));
    bus.Load = 1'b0;
    @(negedge clk);
    check("dv_pulse", {31'd0, bus.data_valid}, 32'd0);
    check("ready_back", {31'd0, bus.ready}, 32'd1);
  endtask

  initial begin
    int base_dv;
    bus.mem_en  = 1'b0;
    bus.Load    = 1'b0;
    bus.addr    = '0;
    bus.data_i  = '0;
    bus.masking = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_dv", {31'd0, bus.data_valid}, 32'd0);
    check("rst_data_o", bus.data_o, 32'd0);
`ifdef DMEM_RANGE_CHECK_EN
    check("rst_err", {31'd0, bus.err}, 32'd0);
`endif

    // Full-word store then load
    txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0);
    txn(1'b0, 1'b1, 32'h10, 32'h0, 4'b0000, 1'b0);
    // Byte-masked store, then zero-mask store that must not write
    txn(1'b1, 1'b0, 32'h11, 32'h00005500, 4'b0010, 1'b0);
    txn(1'b0, 1'b1, 32'h10, 32'h0, 4'b0000, 1'b0);
    txn(1'b1, 1'b0, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0);
    txn(1'b0, 1'b1, 32'h10, 32'h0, 4'b0000, 1'b0);

    // Simultaneous store+load: store wins; a load held while busy is ignored
    txn(1'b1, 1'b1, 32'h20, 32'h12345678, 4'b1111, 1'b1);
    base_dv = dv_count;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", {31'd0, bus.ready}, 32'd1);
    end
    check("no_extra_dv", 32'(dv_count), 32'(base_dv));
    txn(1'b0, 1'b1, 32'h20, 32'h0, 4'b0000, 1'b0);

    // Reset during WAIT discards the pending store
    txn(1'b1, 1'b0, 32'h30, 32'hA5A5A5A5, 4'b1111, 1'b0);
    bus.mem_en  = 1'b1;
    bus.addr    = 32'h30;
    bus.data_i  = 32'h11111111;
    bus.masking = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    bus.mem_en = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, bus.ready}, 32'd1);
    check("midrst_dv", {31'd0, bus.data_valid}, 32'd0);
    check("midrst_data_o", bus.data_o, 32'd0);
    model_dout = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn(1'b0, 1'b1, 32'h30, 32'h0, 4'b0000, 1'b0);

    // Address beyond the RAM: flagged or aliased depending on build
    txn(1'b1, 1'b0, 32'h0, 32'hCAFEF00D, 4'b1111, 1'b0);
    txn(1'b0, 1'b1, 32'h1000, 32'h0, 4'b0000, 1'b0);
    txn(1'b0, 1'b1, 32'h0, 32'h0, 4'b0000, 1'b0);

    // Randomised masked traffic over a prefilled window
    for (int k = 0; k < 16; k++)
      txn(1'b1, 1'b0, 32'h40 + 32'(4 * k), $urandom, 4'b1111, 1'b0);
    for (int k = 0; k < 16; k++) begin
      logic [31:0] a;
      a = 32'h40 + 32'(4 * $urandom_range(15)) + 32'($urandom_range(3));
      if ($urandom_range(1) == 1)
        txn(1'b1, 1'b0, a, $urandom, 4'($urandom_range(15)), 1'b0);
      else
        txn(1'b0, 1'b1, a, 32'h0, 4'b0000, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
